// File: rtl/rst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rst_sequencer_pkg
//  Description : Shared definitions for the reset sequencer: FSM state
//                encoding and state type.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package rst_sequencer_pkg;

    // State encoding is visible on the seq_state port, so values are fixed.
    typedef enum logic [1:0] {
        ST_COLD    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_STAGGER = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_t;

endpackage : rst_sequencer_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Plain two-flop synchroniser for a bus of independent
//                asynchronous level signals.
//  Ports       : clk200    - destination clock
//                sys_rst_n - synchronous active-low reset (flops clear to 0)
//                async_in  - asynchronous inputs, WIDTH bits
//                sync_out  - synchronised outputs, WIDTH bits
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff
    import rst_sequencer_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk200,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk200) begin
        if (!sys_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rst_sequencer
//  Description : Power-on reset generator followed by ordered, staggered
//                release of NUM_CH downstream reset domains. Each domain is
//                released only when its synchronised ready input is high.
//                Losing ready on a released domain re-sequences from the
//                lowest lost domain upward; ext_rst_req restarts everything.
//  Ports       : clk200       - single clock
//                sys_rst_n    - synchronous active-low reset
//                ext_rst_req  - level request for a full cold restart
//                ch_ready     - per-channel ready (asynchronous)
//                ch_rst       - per-domain reset, active high
//                all_released - registered flag, every ch_rst bit is 0
//                seq_state    - FSM state (COLD/WAIT/STAGGER/RUN = 0..3)
//                loss_cnt     - per-channel saturating loss counters
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 14,
    parameter int STAGGER = 16,
    parameter int LOSS_W  = 8
) (
    input  logic                     clk200,
    input  logic                     sys_rst_n,
    input  logic                     ext_rst_req,
    input  logic [NUM_CH-1:0]        ch_ready,
    output logic [NUM_CH-1:0]        ch_rst,
    output logic                     all_released,
    output logic [1:0]               seq_state,
    output logic [NUM_CH*LOSS_W-1:0] loss_cnt
);

    localparam int c_PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    // One counter serves both the cold hold and the stagger gap.
    localparam int c_CW = (CNT_W > c_SW) ? CNT_W : c_SW;

    localparam logic [c_CW-1:0]   c_COLD_LAST = c_CW'({CNT_W{1'b1}});
    localparam logic [c_CW-1:0]   c_STG_LAST  = c_CW'(STAGGER - 1);
    localparam logic [c_CW-1:0]   c_CNT_ONE   = c_CW'(1);
    localparam logic [c_PW-1:0]   c_LAST_CH   = c_PW'(NUM_CH - 1);
    localparam logic [c_PW-1:0]   c_PTR_ONE   = c_PW'(1);
    localparam logic [LOSS_W-1:0] c_LOSS_MAX  = {LOSS_W{1'b1}};
    localparam logic [LOSS_W-1:0] c_LOSS_ONE  = LOSS_W'(1);

    seq_state_t         r_state, w_state_nx;
    logic [c_CW-1:0]    r_cnt, w_cnt_nx;
    logic [c_PW-1:0]    r_ptr, w_ptr_nx;
    logic [NUM_CH-1:0]  r_ch_rst, w_ch_rst_nx;
    logic               r_all_rel;

    logic [NUM_CH-1:0]  w_rdy_s;
    logic [NUM_CH-1:0]  w_lost;
    logic [NUM_CH-1:0]  w_clr;
    logic [c_PW-1:0]    w_lost_idx;

    sync_2ff #(
        .WIDTH     (NUM_CH)
    ) u_sync (
        .clk200    (clk200),
        .sys_rst_n (sys_rst_n),
        .async_in  (ch_ready),
        .sync_out  (w_rdy_s)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_ptr_nx    = r_ptr;
        w_ch_rst_nx = r_ch_rst;
        w_lost      = '0;
        w_clr       = '0;
        w_lost_idx  = '0;

        // A released domain whose ready has dropped is lost. COLD never has
        // a released domain, but gating keeps the intent explicit.
        if (r_state != ST_COLD) begin
            w_lost = ~r_ch_rst & ~w_rdy_s;
        end

        // Lowest lost index (scan downward so the lowest one wins).
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_lost[i]) begin
                w_lost_idx = c_PW'(i);
            end
        end

        // Re-assert every domain at or above the lowest lost one.
        for (int j = 0; j < NUM_CH; j++) begin
            for (int k = 0; k <= j; k++) begin
                if (w_lost[k]) begin
                    w_clr[j] = 1'b1;
                end
            end
        end

        if (ext_rst_req) begin
            w_state_nx  = ST_COLD;
            w_cnt_nx    = '0;
            w_ptr_nx    = '0;
            w_ch_rst_nx = '1;
        end else if (|w_lost) begin
            // Overrides any release of a higher channel this cycle.
            w_state_nx  = ST_WAIT;
            w_cnt_nx    = '0;
            w_ptr_nx    = w_lost_idx;
            w_ch_rst_nx = r_ch_rst | w_clr;
        end else begin
            case (r_state)
                ST_COLD: begin
                    if (r_cnt == c_COLD_LAST) begin
                        w_state_nx = ST_WAIT;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx   = r_cnt + c_CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (w_rdy_s[r_ptr]) begin
                        w_ch_rst_nx[r_ptr] = 1'b0;
                        w_cnt_nx           = '0;
                        w_state_nx         = ST_STAGGER;
                    end
                end
                ST_STAGGER: begin
                    if (r_cnt == c_STG_LAST) begin
                        w_cnt_nx = '0;
                        if (r_ptr == c_LAST_CH) begin
                            w_state_nx = ST_RUN;
                        end else begin
                            w_ptr_nx   = r_ptr + c_PTR_ONE;
                            w_state_nx = ST_WAIT;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + c_CNT_ONE;
                    end
                end
                ST_RUN: begin
                    w_state_nx = ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk200) begin
        if (!sys_rst_n) begin
            r_state   <= ST_COLD;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_ch_rst  <= '1;
            r_all_rel <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_ptr     <= w_ptr_nx;
            r_ch_rst  <= w_ch_rst_nx;
            // Follows the registered ch_rst, so it lags it by one cycle.
            r_all_rel <= (r_ch_rst == '0);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel saturating loss counters. Losses are counted even when
    // ext_rst_req wins the cycle; only sys_rst_n clears them.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_loss
        logic [LOSS_W-1:0] r_loss;

        always_ff @(posedge clk200) begin
            if (!sys_rst_n) begin
                r_loss <= '0;
            end else if (w_lost[gi] && (r_loss != c_LOSS_MAX)) begin
                r_loss <= r_loss + c_LOSS_ONE;
            end
        end

        assign loss_cnt[gi*LOSS_W +: LOSS_W] = r_loss;
    end

    assign ch_rst       = r_ch_rst;
    assign all_released = r_all_rel;
    assign seq_state    = r_state;

endmodule : rst_sequencer
`default_nettype wire

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised successor to the single cold-reset counter in the board top.
- Generates a power-on reset, then releases NUM_CH downstream reset domains one at a time, in index order. A domain is released only once its ready condition holds, and consecutive releases are spaced by STAGGER cycles. Typical ready conditions are SFP clock alarm clear, RX_LOS low, or PLL locked.
- Re-sequences on ready loss or on an external request, and counts loss events per channel.
- Sits between the board top and eth_top and per-port logic; its active-high ch_rst outputs feed the existing sys_rst-style inputs.

Parameters:
- NUM_CH, 2, number of reset domains; must be at least 1.
- CNT_W, 14, cold-reset counter width; cold hold is 2^CNT_W cycles.
- STAGGER, 16, cycles between one channel's release and the next channel's evaluation; must be at least 1.
- LOSS_W, 8, width of each per-channel saturating loss counter.

Ports:
- clk200  in  1  single clock for all logic.
- sys_rst_n  in  1  synchronous, active-low reset.
- ext_rst_req  in  1  level-sensitive request to restart the full sequence; synchronous to clk200.
- ch_ready  in  NUM_CH  per-channel ready condition; asynchronous, synchronised internally.
- ch_rst  out  NUM_CH  per-domain reset, active high; bit i belongs to channel i.
- all_released  out  1  high when every ch_rst bit is 0.
- seq_state  out  2  current FSM state: COLD=0, WAIT=1, STAGGER=2, RUN=3.
- loss_cnt  out  NUM_CH*LOSS_W  per-channel loss counters; channel i occupies bits [i*LOSS_W +: LOSS_W].

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (sys_rst_n sampled on clk200).
- Reset values while sys_rst_n=0:
  - ch_rst all 1s, all_released=0, seq_state=COLD, loss_cnt all 0.
  - Internal cnt=0, ptr=0, synchroniser flops 0.
- Priority: sys_rst_n, then ext_rst_req, then loss detection, then normal FSM.
- ch_ready passes through a 2-flop synchroniser to give rdy_s. A change on a ch_ready pin therefore reaches ch_rst on the 3rd rising edge.
- COLD:
  - cnt increments each cycle.
  - When cnt == 2^CNT_W-1: go to WAIT, cnt<=0.
  - ch_rst stays all 1s throughout.
- WAIT:
  - When rdy_s[ptr]=1: ch_rst[ptr]<=0, cnt<=0, go to STAGGER.
  - Otherwise stay in WAIT. There is no timeout.
- STAGGER:
  - cnt increments each cycle.
  - When cnt == STAGGER-1 and ptr == NUM_CH-1: go to RUN.
  - When cnt == STAGGER-1 and ptr < NUM_CH-1: ptr<=ptr+1, go to WAIT.
- RUN: hold state. all_released is a registered output, equal to (ch_rst == 0).
- Loss detection (evaluated in WAIT, STAGGER and RUN):
  - A channel i is lost when ch_rst[i]=0 and rdy_s[i]=0.
  - Let L be the lowest lost index. ch_rst[j]<=1 for all j >= L, ptr<=L, cnt<=0, go to WAIT.
  - Every lost channel in the same cycle increments its loss_cnt, saturating at 2^LOSS_W-1.
  - Channels below L are unaffected.
- ext_rst_req=1:
  - Next state COLD, cnt<=0, ptr<=0, ch_rst all 1s.
  - loss_cnt is preserved.
  - While held high, stay in COLD with cnt=0. Counting starts on the first cycle after it drops.
- Simultaneous events:
  - Loss in the same cycle as ext_rst_req: ext_rst_req wins, but the loss is still counted.
  - A channel becomes ready in the same cycle that a lower channel is lost: the loss wins.
- sys_rst_n asserted mid-sequence returns all outputs to their reset values on the next edge, including loss_cnt.
- NUM_CH=1: after the STAGGER count completes, go straight to RUN.

Decomposition:
- rst_sequencer_pkg holds the state encoding constants (ST_COLD, ST_WAIT, ST_STAGGER, ST_RUN) and the state type.
- Sub-module sync_2ff, parametrised by WIDTH, a plain 2-flop synchroniser; one instance of width NUM_CH.
- ptr width is clog2(NUM_CH), minimum 1.

Test Plan:
All scenarios use NUM_CH=2, CNT_W=4, STAGGER=3, LOSS_W=2 unless stated.
- Power-up: sys_rst_n low 5 cycles, then high; ch_ready=2'b11 throughout -> ch_rst stays 2'b11 for 16 cycles; ch_rst[0] falls in WAIT; ch_rst[1] falls 4 cycles after ch_rst[0]; all_released=1 one cycle later; seq_state=3.
- Gated release: ch_ready=2'b01 -> FSM parks in WAIT with ptr=1 and ch_rst=2'b10. Raise ch_ready[1] -> ch_rst[1] falls 3 edges later.
- Loss in RUN: drop ch_ready[0] -> 3 edges later ch_rst=2'b11, seq_state=1, loss_cnt[0]=1, loss_cnt[1]=0. Restore ch_ready[0] -> full re-release with STAGGER spacing.
- Saturation and simultaneous loss: drop both ready bits together 4 times from RUN -> loss_cnt[0]=loss_cnt[1]=3 with no wrap; ptr=0 after each loss.
- ext_rst_req held 10 cycles during STAGGER -> seq_state=0 and cnt=0 throughout; after release, 16 cold cycles pass before ch_rst[0] can fall; loss_cnt unchanged.
- sys_rst_n pulsed low in RUN with loss_cnt[0]=2 -> next edge: ch_rst=2'b11, loss_cnt all 0, all_released=0.
